cannon_fire_scheduler: RTL and testbench

- Sequences the spaceship's single shared projectile resource between the top and bottom cannons.
- Arbitrates fire requests and tracks the live shot's vertical position once per frame tick.
- Enforces a cooldown before the next shot.
- Outputs feed the pixel-fill logic, which draws the shot at (SHOT_X, shot_y) when shot_active is high.

---
 rtl/game_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/cannon_fire_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_cannon_fire_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and screen constants
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLIGHT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int H_ORIGIN = 144;
    localparam int V_ORIGIN = 35;
    localparam int Y_MIN    = 35;
    localparam int Y_MAX    = 515;
    localparam int SHOT_X   = 464;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter with advance enable
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic gnt_a,
    output logic gnt_b
);

    // last_b_q set means b won last, so a wins the next contention
    logic last_b_q;
    logic last_b_d;

    always_comb begin
        gnt_a = req_a && (!req_b || last_b_q);
        gnt_b = req_b && (!req_a || !last_b_q);
        last_b_d = last_b_q;
        if (advance && gnt_a) begin
            last_b_d = 1'b0;
        end else if (advance && gnt_b) begin
            last_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/cannon_fire_scheduler.sv
// rtl/cannon_fire_scheduler.sv - shared-projectile scheduler for top/bottom cannons
// Optional macro CANNON_QUEUE_EN adds a one-deep pending flag per requester.
module cannon_fire_scheduler #(
    parameter int STEP           = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int CD_W           = 4,
    parameter int TOP_START_Y    = 186,
    parameter int BOT_START_Y    = 366,
    parameter int Y_MIN          = game_pkg::Y_MIN,
    parameter int Y_MAX          = game_pkg::Y_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_top,
    input  logic       req_bot,
    output logic       grant_top,
    output logic       grant_bot,
    output logic       shot_active,
    output logic       shot_dir,
    output logic [9:0] shot_y,
    output logic       busy
);
    import game_pkg::*;

    localparam logic [10:0]     UP_LIMIT   = 11'(Y_MIN + STEP);
    localparam logic [10:0]     DOWN_LIMIT = 11'(Y_MAX);
    localparam logic [10:0]     STEP11     = 11'(STEP);
    localparam logic [9:0]      TOP_Y0     = 10'(TOP_START_Y);
    localparam logic [9:0]      BOT_Y0     = 10'(BOT_START_Y);
    localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(COOLDOWN_TICKS);
    localparam logic [CD_W-1:0] CD_ONE     = CD_W'(1);

    state_t          state_q, state_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic [9:0]      shot_y_q, shot_y_d;
    logic            shot_dir_q, shot_dir_d;
    logic            shot_active_q, shot_active_d;
    logic            grant_top_q, grant_top_d;
    logic            grant_bot_q, grant_bot_d;
    logic            busy_q, busy_d;

    logic        arb_req_top, arb_req_bot;
    logic        arb_gnt_top, arb_gnt_bot;
    logic        arb_advance;
    logic [10:0] y_ext, y_next;
    logic        shot_end;

`ifdef CANNON_QUEUE_EN
    logic pend_top_q, pend_top_d;
    logic pend_bot_q, pend_bot_d;
    logic req_top_prev_q, req_bot_prev_q;

    assign arb_req_top = req_top | pend_top_q;
    assign arb_req_bot = req_bot | pend_bot_q;

    // Only a fresh press while busy is remembered; a held level re-arbitrates anyway
    always_comb begin
        pend_top_d = pend_top_q;
        pend_bot_d = pend_bot_q;
        if (state_q != ST_IDLE && req_top && !req_top_prev_q) pend_top_d = 1'b1;
        if (state_q != ST_IDLE && req_bot && !req_bot_prev_q) pend_bot_d = 1'b1;
        if (arb_advance && arb_gnt_top) pend_top_d = 1'b0;
        if (arb_advance && arb_gnt_bot) pend_bot_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_top_q     <= 1'b0;
            pend_bot_q     <= 1'b0;
            req_top_prev_q <= 1'b0;
            req_bot_prev_q <= 1'b0;
        end else begin
            pend_top_q     <= pend_top_d;
            pend_bot_q     <= pend_bot_d;
            req_top_prev_q <= req_top;
            req_bot_prev_q <= req_bot;
        end
    end
`else
    assign arb_req_top = req_top;
    assign arb_req_bot = req_bot;
`endif

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst),
        .req_a   (arb_req_top),
        .req_b   (arb_req_bot),
        .advance (arb_advance),
        .gnt_a   (arb_gnt_top),
        .gnt_b   (arb_gnt_bot)
    );

    // 11-bit arithmetic keeps the down-shot sum from wrapping past 1023
    always_comb begin
        y_ext = {1'b0, shot_y_q};
        if (shot_dir_q == DIR_UP) begin
            shot_end = y_ext < UP_LIMIT;
            y_next   = y_ext - STEP11;
        end else begin
            shot_end = (y_ext + STEP11) > DOWN_LIMIT;
            y_next   = y_ext + STEP11;
        end
    end

    always_comb begin
        state_d       = state_q;
        cd_d          = cd_q;
        shot_y_d      = shot_y_q;
        shot_dir_d    = shot_dir_q;
        shot_active_d = shot_active_q;
        grant_top_d   = 1'b0;
        grant_bot_d   = 1'b0;
        arb_advance   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt_top || arb_gnt_bot) begin
                    arb_advance   = 1'b1;
                    grant_top_d   = arb_gnt_top;
                    grant_bot_d   = arb_gnt_bot;
                    shot_y_d      = arb_gnt_top ? TOP_Y0 : BOT_Y0;
                    shot_dir_d    = arb_gnt_top ? DIR_UP : DIR_DOWN;
                    shot_active_d = 1'b1;
                    state_d       = ST_FLIGHT;
                end
            end
            ST_FLIGHT: begin
                if (tick) begin
                    if (shot_end) begin
                        shot_active_d = 1'b0;
                        if (COOLDOWN_TICKS > 0) begin
                            cd_d    = CD_LOAD;
                            state_d = ST_COOLDOWN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shot_y_d = y_next[9:0];
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (cd_q <= CD_ONE) begin
                        cd_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cd_d = cd_q - CD_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cd_q          <= '0;
            shot_y_q      <= '0;
            shot_dir_q    <= 1'b0;
            shot_active_q <= 1'b0;
            grant_top_q   <= 1'b0;
            grant_bot_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cd_q          <= cd_d;
            shot_y_q      <= shot_y_d;
            shot_dir_q    <= shot_dir_d;
            shot_active_q <= shot_active_d;
            grant_top_q   <= grant_top_d;
            grant_bot_q   <= grant_bot_d;
            busy_q        <= busy_d;
        end
    end

    assign grant_top   = grant_top_q;
    assign grant_bot   = grant_bot_q;
    assign shot_active = shot_active_q;
    assign shot_dir    = shot_dir_q;
    assign shot_y      = shot_y_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cannon_fire_scheduler.sv
// tb/tb_cannon_fire_scheduler.sv - randomized self-checking bench against a rule-level model
module tb_cannon_fire_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       req_top = 1'b0;
    logic       req_bot = 1'b0;
    logic       grant_top, grant_bot, shot_active, shot_dir, busy;
    logic [9:0] shot_y;

    int total = 0;
    int bad = 0;

    cannon_fire_scheduler dut (
        .clk         (clk),
        .rst         (rst_n),
        .tick        (tick),
        .req_top     (req_top),
        .req_bot     (req_bot),
        .grant_top   (grant_top),
        .grant_bot   (grant_bot),
        .shot_active (shot_active),
        .shot_dir    (shot_dir),
        .shot_y      (shot_y),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 shot in the air, 2 waiting out the cooldown
    int m_phase, m_cool, m_y, m_dir, m_act, m_gt, m_gb;
    bit m_last_top;
    bit m_pend_t, m_pend_b, m_prev_t, m_prev_b;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cool = 0; m_y = 0; m_dir = 0; m_act = 0;
        m_gt = 0; m_gb = 0; m_last_top = 1'b0;
        m_pend_t = 1'b0; m_pend_b = 1'b0; m_prev_t = 1'b0; m_prev_b = 1'b0;
    endtask

    task automatic model_step(input bit rt, input bit rb, input bit tk);
        bit want_t, want_b, pick_top;
        want_t = rt;
        want_b = rb;
`ifdef CANNON_QUEUE_EN
        want_t = rt | m_pend_t;
        want_b = rb | m_pend_b;
        if (m_phase != 0 && rt && !m_prev_t) m_pend_t = 1'b1;
        if (m_phase != 0 && rb && !m_prev_b) m_pend_b = 1'b1;
        m_prev_t = rt;
        m_prev_b = rb;
`endif
        m_gt = 0;
        m_gb = 0;
        if (m_phase == 0) begin
            if (want_t || want_b) begin
                pick_top = want_t && (!want_b || !m_last_top);
                m_last_top = pick_top;
                if (pick_top) begin m_gt = 1; m_y = 186; m_dir = 0; m_pend_t = 1'b0; end
                else          begin m_gb = 1; m_y = 366; m_dir = 1; m_pend_b = 1'b0; end
                m_act = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1 && tk) begin
            if ((m_dir == 0 && m_y < 35 + 4) || (m_dir == 1 && m_y + 4 > 515)) begin
                m_act = 0;
                m_cool = 8;
                m_phase = 2;
            end else begin
                m_y = (m_dir == 0) ? m_y - 4 : m_y + 4;
            end
        end else if (m_phase == 2 && tk) begin
            m_cool--;
            if (m_cool == 0) m_phase = 0;
        end
    endtask

    task automatic cyc(input bit rt, input bit rb, input bit tk);
        req_top = rt;
        req_bot = rb;
        tick    = tk;
        @(posedge clk);
        model_step(rt, rb, tk);
        #1;
        chk("grant_top", grant_top, m_gt);
        chk("grant_bot", grant_bot, m_gb);
        chk("shot_active", shot_active, m_act);
        chk("shot_dir", shot_dir, m_dir);
        chk("shot_y", shot_y, m_y);
        chk("busy", busy, (m_phase != 0) ? 1 : 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_phase != 0 && n < 600) begin
            cyc(1'b0, 1'b0, 1'b1);
            n++;
        end
        if (m_phase != 0) chk("drain_timeout", 1, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gt"}, grant_top, 0);
        chk({tag, "_gb"}, grant_bot, 0);
        chk({tag, "_act"}, shot_active, 0);
        chk({tag, "_dir"}, shot_dir, 0);
        chk({tag, "_y"}, shot_y, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int end_at, idle_at, n, ng;
        int seq[3];
        int exp_q;
        bit rt, rb;

        model_reset();
        #3;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Top shot: launch, fly up, cool down
        cyc(1'b1, 1'b0, 1'b0);
        chk("top_y0", shot_y, 186);
        cyc(1'b0, 1'b0, 1'b1);
        chk("top_y1", shot_y, 182);
        end_at = 0; idle_at = 0;
        for (int i = 2; i < 200; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (!shot_active && end_at == 0) begin
                end_at = i;
                chk("top_last_y", shot_y, 38);
            end
            if (!busy) begin idle_at = i; break; end
        end
        chk("top_flight_ticks", end_at, 38);
        chk("top_cool_ticks", idle_at - end_at, 8);

        // Bottom held: two shots, second on the first idle clk
        ng = 0; n = 0;
        while (ng < 2 && n < 400) begin
            cyc(1'b0, 1'b1, n[0]);
            if (grant_bot) ng++;
            if (shot_dir && shot_active && n > 0) chk("bot_y_range", (shot_y >= 366 && shot_y <= 514) ? 1 : 0, 1);
            n++;
        end
        chk("bot_two_grants", ng, 2);
        drain();

        // Both held: round-robin top, bottom, top
        ng = 0; n = 0;
        while (ng < 3 && n < 600) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (grant_top) begin seq[ng] = 0; ng++; end
            else if (grant_bot) begin seq[ng] = 1; ng++; end
            n++;
        end
        chk("rr_count", ng, 3);
        chk("rr_0", seq[0], 0);
        chk("rr_1", seq[1], 1);
        chk("rr_2", seq[2], 0);
        drain();

        // req_top pressed during flight and cooldown, released before idle
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        n = 0;
        while (m_phase != 2 && n < 200) begin cyc(1'b0, 1'b0, 1'b1); n++; end
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        drain();
        ng = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (grant_top) ng++;
        end
`ifdef CANNON_QUEUE_EN
        exp_q = 1;
`else
        exp_q = 0;
`endif
        chk("busy_req_grants", ng, exp_q);
        drain();

        // Asynchronous reset mid-flight at shot_y=150
        cyc(1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_y != 150 && n < 50) begin cyc(1'b0, 1'b0, 1'b1); n++; end
        chk("pre_rst_y", shot_y, 150);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_y", shot_y, 186);
        chk("post_rst_gt", grant_top, 1);
        drain();

        // Random traffic
        rt = 1'b0; rb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) rt = ~rt;
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            cyc(rt, rb, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
